// File: rtl/regstat_file.sv
// regstat_file: architectural register file with per-register busy/tag
// tracking. Combinational read ports with commit bypass, one issue
// (rename) port, one commit port and a global flush of pending producers.
module regstat_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int TAG_W   = 4,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NRD*ADDR_W-1:0] RAddr,
  output logic [NRD*DATA_W-1:0] RVal,
  output logic [NRD-1:0]        RBusy,
  output logic [NRD*TAG_W-1:0]  RTag,
  input  logic                  Issue,
  input  logic [ADDR_W-1:0]     IssueAddr,
  input  logic [TAG_W-1:0]      IssueTag,
  input  logic                  Commit,
  input  logic [ADDR_W-1:0]     CommitAddr,
  input  logic [TAG_W-1:0]      CommitTag,
  input  logic [DATA_W-1:0]     CommitVal,
  input  logic                  Flush
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [TAG_W-1:0]  tags [NREG];
  logic [NREG-1:0]   busy;

  logic commit_ok;
  logic issue_ok;
  logic commit_clr;

  // Qualify requests: register 0 is inert when hard-wired, flush drops issue
  always_comb begin
    commit_ok  = Commit && !((ZERO_R0 != 0) && (CommitAddr == '0));
    issue_ok   = Issue && !Flush && !((ZERO_R0 != 0) && (IssueAddr == '0));
    commit_clr = commit_ok && busy[CommitAddr] && (tags[CommitAddr] == CommitTag);
  end

  // Value, busy and tag state; a same-register issue overrides the commit clear
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (commit_ok)
        regs[CommitAddr] <= CommitVal;
      if (issue_ok)
        tags[IssueAddr] <= IssueTag;
      if (Flush) begin
        busy <= '0;
      end else begin
        if (commit_clr)
          busy[CommitAddr] <= 1'b0;
        if (issue_ok)
          busy[IssueAddr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              hit;
    logic [DATA_W-1:0] val;
    logic              bsy;
    logic [TAG_W-1:0]  tg;

    assign a = RAddr[k*ADDR_W +: ADDR_W];

    // Read port: bypass the in-flight commit, but never during reset so the
    // outputs stay cleared while Rst is held
    always_comb begin
      is_zero = (ZERO_R0 != 0) && (a == '0);
      hit     = Commit && !Rst && (CommitAddr == a) && !is_zero;
      val     = hit ? CommitVal : regs[a];
      bsy     = busy[a] && !(hit && (tags[a] == CommitTag)) && !Flush;
      tg      = tags[a];
      if (is_zero) begin
        val = '0;
        bsy = 1'b0;
        tg  = '0;
      end
    end

    assign RVal[k*DATA_W +: DATA_W] = val;
    assign RBusy[k]                 = bsy;
    assign RTag[k*TAG_W +: TAG_W]   = tg;
  end

endmodule

// File: tb/tb_regstat_file.sv
// tb_regstat_file: directed checks of regstat_file with three read ports.
module tb_regstat_file;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int TW = 4;
  localparam int NR = 3;

  logic              Clk;
  logic              Rst;
  logic [NR*AW-1:0]  RAddr;
  logic [NR*DW-1:0]  RVal;
  logic [NR-1:0]     RBusy;
  logic [NR*TW-1:0]  RTag;
  logic              Issue;
  logic [AW-1:0]     IssueAddr;
  logic [TW-1:0]     IssueTag;
  logic              Commit;
  logic [AW-1:0]     CommitAddr;
  logic [TW-1:0]     CommitTag;
  logic [DW-1:0]     CommitVal;
  logic              Flush;

  int checks = 0;
  int errors = 0;

  regstat_file #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TAG_W  (TW),
    .NRD    (NR),
    .ZERO_R0(1)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .RAddr     (RAddr),
    .RVal      (RVal),
    .RBusy     (RBusy),
    .RTag      (RTag),
    .Issue     (Issue),
    .IssueAddr (IssueAddr),
    .IssueTag  (IssueTag),
    .Commit    (Commit),
    .CommitAddr(CommitAddr),
    .CommitTag (CommitTag),
    .CommitVal (CommitVal),
    .Flush     (Flush)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_all(input int a);
    for (int k = 0; k < NR; k++) RAddr[k*AW +: AW] = a[AW-1:0];
  endtask

  // Point every port at register a and compare all of them
  task automatic rd(input string nm, input int a, input logic [31:0] ev,
                    input logic eb, input logic [3:0] et, input bit chk_tag);
    set_all(a);
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s.val%0d", nm, k), 64'(RVal[k*DW +: DW]), 64'(ev));
      check($sformatf("%s.busy%0d", nm, k), 64'(RBusy[k]), 64'(eb));
      if (chk_tag)
        check($sformatf("%s.tag%0d", nm, k), 64'(RTag[k*TW +: TW]), 64'(et));
    end
  endtask

  task automatic idle();
    Issue = 1'b0; Commit = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    IssueAddr = '0; IssueTag = '0; CommitAddr = '0; CommitTag = '0; CommitVal = '0;
    RAddr = '0;

    // Reset held: random addresses, plus a commit that must be discarded
    for (int k = 0; k < NR; k++) RAddr[k*AW +: AW] = AW'($urandom_range(0, 63));
    RAddr[0 +: AW] = 6'd5;
    Commit = 1'b1; CommitAddr = 6'd5; CommitTag = 4'd0; CommitVal = 32'hAAAA;
    tick();
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rst.val%0d", k), 64'(RVal[k*DW +: DW]), 64'd0);
      check($sformatf("rst.busy%0d", k), 64'(RBusy[k]), 64'd0);
      check($sformatf("rst.tag%0d", k), 64'(RTag[k*TW +: TW]), 64'd0);
    end
    tick();
    Rst = 1'b0;
    idle();
    rd("r5", 5, 32'h0, 1'b0, 4'd0, 1'b1);

    // Issue r3 tag 7: not bypassed in the same cycle
    Issue = 1'b1; IssueAddr = 6'd3; IssueTag = 4'd7;
    rd("iss_same", 3, 32'h0, 1'b0, 4'd0, 1'b0);
    tick(); idle();
    rd("iss_r3", 3, 32'h0, 1'b1, 4'd7, 1'b1);
    Commit = 1'b1; CommitAddr = 6'd3; CommitTag = 4'd7; CommitVal = 32'hDEADBEEF;
    rd("cm_byp", 3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);
    tick(); idle();
    rd("cm_r3", 3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);

    // Tag mismatch keeps the register busy
    Issue = 1'b1; IssueAddr = 6'd4; IssueTag = 4'd2;
    tick();
    IssueTag = 4'd9;
    tick(); idle();
    Commit = 1'b1; CommitAddr = 6'd4; CommitTag = 4'd2; CommitVal = 32'h11;
    rd("mm_byp", 4, 32'h11, 1'b1, 4'd9, 1'b1);
    tick(); idle();
    rd("mm_r4", 4, 32'h11, 1'b1, 4'd9, 1'b1);
    Commit = 1'b1; CommitAddr = 6'd4; CommitTag = 4'd9; CommitVal = 32'h22;
    rd("mm2_byp", 4, 32'h22, 1'b0, 4'd0, 1'b0);
    tick(); idle();
    rd("mm2_r4", 4, 32'h22, 1'b0, 4'd0, 1'b0);

    // Issue and matching commit to r6 in one cycle: issue wins busy/tag
    Issue = 1'b1; IssueAddr = 6'd6; IssueTag = 4'd1;
    tick(); idle();
    Issue = 1'b1; IssueAddr = 6'd6; IssueTag = 4'd5;
    Commit = 1'b1; CommitAddr = 6'd6; CommitTag = 4'd1; CommitVal = 32'h33;
    rd("sim_byp", 6, 32'h33, 1'b0, 4'd0, 1'b0);
    tick(); idle();
    rd("sim_r6", 6, 32'h33, 1'b1, 4'd5, 1'b1);

    // Flush with issue r8 and commit r9; r6 busy must drop even combinationally
    Flush = 1'b1;
    Issue = 1'b1; IssueAddr = 6'd8; IssueTag = 4'd3;
    Commit = 1'b1; CommitAddr = 6'd9; CommitTag = 4'd0; CommitVal = 32'h55;
    rd("fl_r6c", 6, 32'h33, 1'b0, 4'd0, 1'b0);
    tick(); idle();
    rd("fl_r8", 8, 32'h0, 1'b0, 4'd0, 1'b0);
    rd("fl_r6", 6, 32'h33, 1'b0, 4'd0, 1'b0);
    rd("fl_r9", 9, 32'h55, 1'b0, 4'd0, 1'b0);

    // Zero register ignores commit and issue
    Commit = 1'b1; CommitAddr = 6'd0; CommitTag = 4'd0; CommitVal = 32'hFFFF;
    Issue = 1'b1; IssueAddr = 6'd0; IssueTag = 4'd3;
    rd("z_byp", 0, 32'h0, 1'b0, 4'd0, 1'b1);
    tick(); idle();
    rd("z_r0", 0, 32'h0, 1'b0, 4'd0, 1'b1);

    // Independent ports on different registers
    RAddr[0*AW +: AW] = 6'd3;
    RAddr[1*AW +: AW] = 6'd4;
    RAddr[2*AW +: AW] = 6'd9;
    #1;
    check("mp.val0", 64'(RVal[0*DW +: DW]), 64'hDEADBEEF);
    check("mp.val1", 64'(RVal[1*DW +: DW]), 64'h22);
    check("mp.val2", 64'(RVal[2*DW +: DW]), 64'h55);

    // Async reset between edges with r2 holding 0x44 and busy on tag 6
    Commit = 1'b1; CommitAddr = 6'd2; CommitTag = 4'd0; CommitVal = 32'h44;
    tick(); idle();
    Issue = 1'b1; IssueAddr = 6'd2; IssueTag = 4'd6;
    tick(); idle();
    rd("ar_pre", 2, 32'h44, 1'b1, 4'd6, 1'b1);
    Rst = 1'b1;
    rd("ar_on", 2, 32'h0, 1'b0, 4'd0, 1'b1);
    Rst = 1'b0;
    rd("ar_off", 2, 32'h0, 1'b0, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
